edge_detector_mc: RTL and testbench

//  Multi-channel, parametrised successor of the single-bit edge detector.

---
 rtl/edge_detector_mc.sv | 124 ++++++++++++
 tb/tb_edge_detector_mc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: per-channel synchroniser, optional debounce
// filter, rising/falling/both edge qualification, sticky pending/overrun
// flags and an OR-reduced interrupt.
// Optional feature: define EDGE_DET_FILTER_EN to enable the per-channel
// debounce counter (filter_len extra stable cycles before level follows).

module edge_det_ch #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  input  logic [1:0]              mode,
  input  logic [FILTER_WIDTH-1:0] filter_len,
  input  logic                    clr,
  output logic                    level,
  output logic                    edge_detected,
  output logic                    edge_type,
  output logic                    pending,
  output logic                    overrun
);
  logic [SYNC_STAGES-1:0] sync;
  logic sync_out, level_d, rise, fall;

  // Synchroniser chain for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], din};
  end
  assign sync_out = sync[SYNC_STAGES-1];

`ifdef EDGE_DET_FILTER_EN
  logic [FILTER_WIDTH-1:0] cnt;
  logic                    level_q;

  // Debounce: level only follows after filter_len+1 consecutive differing
  // samples. If filter_len drops below cnt mid-count, cnt wraps and retries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (sync_out == level_q) begin
      cnt <= '0;
    end else if (cnt == filter_len) begin
      level_q <= sync_out;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  assign level = level_q;
`else
  logic unused_filter;
  assign unused_filter = ^filter_len;
  assign level = sync_out;
`endif

  // Previous level for edge extraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign rise          = level & ~level_d;
  assign fall          = ~level & level_d;
  assign edge_detected = (rise & mode[0]) | (fall & mode[1]);

  // Edge type capture and sticky flags; a new edge beats a same-cycle clear
  // for pending, while clear always wins for overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_type <= 1'b0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (edge_detected) edge_type <= rise;
      if (edge_detected) pending <= 1'b1;
      else if (clr)      pending <= 1'b0;
      if (clr)                          overrun <= 1'b0;
      else if (edge_detected & pending) overrun <= 1'b1;
    end
  end
endmodule

module edge_detector_mc #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CHANNELS-1:0]     data_in,
  input  logic [2*CHANNELS-1:0]   edge_mode,
  input  logic [FILTER_WIDTH-1:0] filter_len,
  input  logic [CHANNELS-1:0]     clr,
  output logic [CHANNELS-1:0]     level,
  output logic [CHANNELS-1:0]     edge_detected,
  output logic [CHANNELS-1:0]     edge_type,
  output logic [CHANNELS-1:0]     pending,
  output logic [CHANNELS-1:0]     overrun,
  output logic                    irq
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_det_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_WIDTH(FILTER_WIDTH)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .din          (data_in[i]),
      .mode         (edge_mode[2*i+1:2*i]),
      .filter_len   (filter_len),
      .clr          (clr[i]),
      .level        (level[i]),
      .edge_detected(edge_detected[i]),
      .edge_type    (edge_type[i]),
      .pending      (pending[i]),
      .overrun      (overrun[i])
    );
  end

  assign irq = |pending;
endmodule

// File: tb/tb_edge_detector_mc.sv
// Scoreboard bench for edge_detector_mc: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever edge_detected is non-zero.
module tb_edge_detector_mc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in, clr, level, edge_detected, edge_type, pending, overrun;
  logic [7:0] edge_mode;
  logic [3:0] filter_len;
  logic       irq;

  typedef struct { int cyc; logic [3:0] mask; } exp_t;
  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  edge_detector_mc #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .edge_mode(edge_mode),
    .filter_len(filter_len), .clr(clr), .level(level),
    .edge_detected(edge_detected), .edge_type(edge_type), .pending(pending),
    .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // cycles from driving at a negedge to the pulse being visible at a negedge
  function automatic int lat();
`ifdef EDGE_DET_FILTER_EN
    return 3 + int'(filter_len);
`else
    return 2;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int ch, input logic v, input logic [3:0] m);
    data_in[ch] = v;
    if (m != 4'b0) sbq.push_back('{cyc + lat(), m});
  endtask

  // Monitor: every pulse must match the next expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && edge_detected !== 4'b0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'(edge_detected), 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_mask", 32'(edge_detected), 32'(e.mask));
      end
    end
  end

  initial begin
    rst_n = 1'b0; data_in = 4'b0; clr = 4'b0; filter_len = 4'd0;
    edge_mode = 8'b11_11_10_01;   // ch3 both, ch2 both, ch1 fall, ch0 rise
    step(3);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_edge", 32'(edge_detected), 32'h0);
    chk("rst_type", 32'(edge_type), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    step(3);

    // 1: rising edge on ch0
    drive(0, 1'b1, 4'b0001);
    step(6);
    chk("t1_type0", 32'(edge_type[0]), 32'h1);
    chk("t1_pending", 32'(pending), 32'h1);
    chk("t1_irq", 32'(irq), 32'h1);
    chk("t1_level0", 32'(level[0]), 32'h1);

    // 2: ch1 falling only
    drive(1, 1'b1, 4'b0); step(5);
    drive(1, 1'b0, 4'b0010); step(5);
    drive(1, 1'b1, 4'b0); step(5);
    chk("t2_type1", 32'(edge_type[1]), 32'h0);
    chk("t2_pending1", 32'(pending[1]), 32'h1);
    chk("t2_overrun1", 32'(overrun[1]), 32'h0);

    // 3: two edges on ch2 without clear -> overrun, then clear
    drive(2, 1'b1, 4'b0100); step(5);
    drive(2, 1'b0, 4'b0100); step(5);
    chk("t3_pending2", 32'(pending[2]), 32'h1);
    chk("t3_overrun2", 32'(overrun[2]), 32'h1);
    chk("t3_type2", 32'(edge_type[2]), 32'h0);
    clr = 4'b0111; step(1); clr = 4'b0; step(1);
    chk("t3_pending_clr", 32'(pending), 32'h0);
    chk("t3_overrun_clr", 32'(overrun), 32'h0);
    chk("t3_irq", 32'(irq), 32'h0);

    // 4: ch3 overrun, then edge coincident with clear
    drive(3, 1'b1, 4'b1000); step(5);
    drive(3, 1'b0, 4'b1000); step(5);
    chk("t4_overrun_pre", 32'(overrun[3]), 32'h1);
    drive(3, 1'b1, 4'b1000);
    step(lat());
    clr[3] = 1'b1; step(1); clr[3] = 1'b0; step(2);
    chk("t4_pending3", 32'(pending[3]), 32'h1);
    chk("t4_overrun3", 32'(overrun[3]), 32'h0);
    chk("t4_type3", 32'(edge_type[3]), 32'h1);
    clr = 4'b1000; step(1); clr = 4'b0; step(1);
    chk("t4_irq", 32'(irq), 32'h0);

`ifdef EDGE_DET_FILTER_EN
    // 5: debounce, 3-cycle glitch ignored, 4-cycle level accepted
    filter_len = 4'd3; step(2);
    drive(2, 1'b1, 4'b0); step(3);
    drive(2, 1'b0, 4'b0); step(8);
    chk("t5_glitch_level", 32'(level[2]), 32'h0);
    chk("t5_glitch_pending", 32'(pending[2]), 32'h0);
    drive(2, 1'b1, 4'b0100); step(10);
    chk("t5_level2", 32'(level[2]), 32'h1);
    chk("t5_pending2", 32'(pending[2]), 32'h1);
    filter_len = 4'd0; step(2);
`endif

    // 6: reset mid-pending with inputs held high
    drive(0, 1'b0, 4'b0); step(5);
    drive(0, 1'b1, 4'b0001); step(6);
    chk("t6_pending_pre", 32'(pending[0]), 32'h1);
    rst_n = 1'b0; data_in = 4'b0101; step(2);
    chk("t6_rst_level", 32'(level), 32'h0);
    chk("t6_rst_edge", 32'(edge_detected), 32'h0);
    chk("t6_rst_type", 32'(edge_type), 32'h0);
    chk("t6_rst_pending", 32'(pending), 32'h0);
    chk("t6_rst_overrun", 32'(overrun), 32'h0);
    chk("t6_rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    sbq.push_back('{cyc + lat(), 4'b0101});
    step(6);
    chk("t6_pending", 32'(pending), 32'h5);
    chk("t6_type", 32'(edge_type), 32'h5);
    chk("t6_irq", 32'(irq), 32'h1);

    step(4);
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
